// File: rtl/rap_vla_ctrl_pkg.sv
// Shared definitions for the variable-latency approximate adder controller.
package rap_pkg;

    // Operation modes as sampled from in_mode. Code 3 is reserved and
    // behaves like MODE_EXACT.
    localparam logic [1:0] MODE_SPEC   = 2'd0;
    localparam logic [1:0] MODE_APPROX = 2'd1;
    localparam logic [1:0] MODE_EXACT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FIX,
        S_HOLD
    } state_t;

    // Number of WIN-bit segments walked by the exact ripple path.
    function automatic int nseg(input int width, input int win);
        return width / win;
    endfunction

endpackage

// File: rtl/rap_vla_ctrl_if.sv
// Operand and result handshake bundle. The producer/consumer side is the
// master; the controller is the slave.
interface rap_vla_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;
    logic             out_corr;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_corr
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_corr
    );
endinterface

// File: rtl/rap_vla_ctrl_win_add.sv
// Windowed approximate adder: every carry only looks back WIN bits, with an
// assumed zero carry into the bottom of its window. det flags any WIN-long
// run of propagate bits, the only way a real carry can cross a window.
module rap_win_add
    import rap_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WIN   = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o,
    output logic             det_o
);
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-WIN:0] run;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        localparam int LO = (i - WIN + 1 < 0) ? 0 : i - WIN + 1;
        logic c_w;
        // Ripple the carry across this bit's window only.
        always_comb begin
            c_w = 1'b0;
            for (int j = LO; j <= i; j++) begin
                c_w = g[j] | (p[j] & c_w);
            end
        end
        assign c[i] = c_w;
    end

    for (genvar i = 0; i <= WIDTH - WIN; i++) begin : g_run
        assign run[i] = &p[i +: WIN];
    end

    assign det_o = |run;
    assign sum_o = {c[WIDTH-1], p[WIDTH-1:1] ^ c[WIDTH-2:0], p[0]};
endmodule

// File: rtl/rap_vla_ctrl.sv
// Variable-latency controller: returns the windowed approximate sum after a
// single evaluation cycle, or ripples the exact sum segment by segment when
// the mode demands it or a carry-window violation may have occurred.
module rap_vla_ctrl
    import rap_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WIN   = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rap_vla_ctrl_if.slave    bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NSEG  = nseg(WIDTH, WIN);
    localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       mode_q;
    logic [SEG_W-1:0] seg_q;
    logic             cin_q;
    logic [WIDTH:0]   sum_q;
    logic             err_q, corr_q, valid_q, rdy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   apx_sum;
    logic             det;
    logic             fast;
    logic [WIN:0]     seg_sum;

    rap_win_add #(.WIDTH(WIDTH), .WIN(WIN)) u_win_add (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (apx_sum),
        .det_o (det)
    );

    // The approximate result is final for APPROX, or for SPEC with no hazard.
    assign fast = (mode_q == MODE_APPROX) || ((mode_q == MODE_SPEC) && !det);

    // One exact WIN-bit slice of the serial correction.
    assign seg_sum = {1'b0, a_q[seg_q*WIN +: WIN]} + {1'b0, b_q[seg_q*WIN +: WIN]}
                   + {{WIN{1'b0}}, cin_q};

    // Operation FSM; all handshake outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_SPEC;
            seg_q   <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            corr_q  <= 1'b0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && rdy_q) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        mode_q  <= bus.in_mode;
                        rdy_q   <= 1'b0;
                        state_q <= S_EVAL;
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                S_EVAL: begin
                    err_q <= det;
                    if (fast) begin
                        sum_q   <= apx_sum;
                        corr_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        seg_q   <= '0;
                        cin_q   <= 1'b0;
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    sum_q[seg_q*WIN +: WIN] <= seg_sum[WIN-1:0];
                    cin_q <= seg_sum[WIN];
                    seg_q <= seg_q + 1'b1;
                    if (seg_q == LAST_SEG) begin
                        sum_q[WIDTH] <= seg_sum[WIN];
                        corr_q       <= 1'b1;
                        valid_q      <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Saturating violation count; a clear beats a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if ((state_q == S_EVAL) && det && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_err   = err_q;
    assign bus.out_corr  = corr_q;
    assign err_cnt       = cnt_q;
endmodule

// File: tb/tb_rap_vla_ctrl.sv
// Bench for rap_vla_ctrl: directed vectors plus random operations checked
// against an arithmetic reference of the windowed adder.
module tb_rap_vla_ctrl;
    import rap_pkg::*;

    localparam int W     = 32;
    localparam int WN    = 8;
    localparam int NS    = W / WN;
    localparam int CW    = 4;   // narrow counter so saturation is reachable quickly
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errs   = 0;
    int ref_cnt = 0;
    logic [W:0] obs_sum;

    rap_vla_ctrl_if #(.WIDTH(W)) bus ();

    rap_vla_ctrl #(.WIDTH(W), .WIN(WN), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Carry out of bit i = carry out of the plain integer sum of the window bits.
    function automatic logic [W:0] ref_approx(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]    s;
        logic [W-1:0]  p, c;
        logic [63:0]   mask, wa, wb, t;
        int lo, len;
        p = a ^ b;
        for (int i = 0; i < W; i++) begin
            lo   = (i - WN + 1 < 0) ? 0 : i - WN + 1;
            len  = i - lo + 1;
            mask = (64'd1 << len) - 64'd1;
            wa   = ({32'd0, a} >> lo) & mask;
            wb   = ({32'd0, b} >> lo) & mask;
            t    = wa + wb;
            c[i] = t[len];
        end
        s[0] = p[0];
        for (int i = 1; i < W; i++) s[i] = p[i] ^ c[i-1];
        s[W] = c[W-1];
        return s;
    endfunction

    function automatic logic ref_det(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p;
        p = a ^ b;
        for (int i = 0; i <= W - WN; i++)
            if (((p >> i) & 32'hFF) == 32'hFF) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                         input int hold, input bit clr_eval);
        logic       d, f;
        logic [W:0] exp_sum;
        int n, lat;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", bus.in_ready, 1);
        d = ref_det(a, b);
        f = (mode == MODE_APPROX) || (mode == MODE_SPEC && !d);
        exp_sum = f ? ref_approx(a, b) : ({1'b0, a} + {1'b0, b});
        if (clr_eval) ref_cnt = 0;
        else if (d && ref_cnt != CMAX) ref_cnt++;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_mode = mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a = $urandom; bus.in_b = $urandom; bus.in_mode = 2'($urandom);
        if (clr_eval) err_clr = 1'b1;
        check("in_ready_busy", bus.in_ready, 0);
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1; err_clr = 1'b0; lat++;
        end
        err_clr = 1'b0;
        obs_sum = bus.out_sum;
        check("latency", 64'(lat), f ? 64'd2 : 64'(2 + NS));
        check("out_sum", 64'(bus.out_sum), 64'(exp_sum));
        check("out_err", bus.out_err, d);
        check("out_corr", bus.out_corr, !f);
        check("err_cnt", err_cnt, 64'(ref_cnt));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_stable", {bus.out_valid, bus.in_ready, 64'(bus.out_sum)},
                  {1'b1, 1'b0, 64'(exp_sum)});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release", {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rm;
        int vcount;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.in_ready, bus.out_valid, bus.out_err, bus.out_corr,
                              64'(bus.out_sum), 4'(err_cnt)}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        do_op(32'h0000_1234, 32'h0000_0101, MODE_SPEC, 0, 0);
        check("t1_sum", 64'(obs_sum), 64'h0_0000_1335);
        check("t1_cnt", err_cnt, 0);
        do_op(32'h0000_FFFF, 32'h0000_0001, MODE_SPEC, 0, 0);
        check("t2_sum", 64'(obs_sum), 64'h0_0001_0000);
        check("t2_cnt", err_cnt, 1);
        do_op(32'h0000_FFFF, 32'h0000_0001, MODE_APPROX, 0, 0);
        check("t3_sum", 64'(obs_sum), 64'h0_0000_FE00);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, MODE_EXACT, 0, 0);
        check("t4_sum", 64'(obs_sum), 64'h1_0000_0000);
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 2'd3, 0, 0);
        do_op(32'h0F0F_0F0F, 32'h00F0_F0F0, MODE_SPEC, 5, 0);

        // Random operations, a third with a forced propagate run
        for (int i = 0; i < 30; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 2) == 0) rb = ra ^ (32'hFF << $urandom_range(0, W - WN));
            do_op(ra, rb, rm, $urandom_range(0, 2), 0);
        end

        // Saturation, then clear racing an increment
        while (ref_cnt < CMAX) do_op(32'h0000_FFFF, 32'h0000_0001, MODE_APPROX, 0, 0);
        do_op(32'h00FF_0000, 32'h0000_0000, MODE_SPEC, 0, 0);
        check("sat_cnt", err_cnt, CMAX);
        do_op(32'h0000_FFFF, 32'h0000_0001, MODE_SPEC, 0, 1);
        check("clr_cnt", err_cnt, 0);
        do_op(32'h0000_FFFF, 32'h0000_0001, MODE_APPROX, 0, 0);

        // Reset during the second FIX cycle abandons the operation
        bus.in_valid = 1'b1; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'h1; bus.in_mode = MODE_EXACT;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset", {bus.in_ready, bus.out_valid, bus.out_err, bus.out_corr,
                            64'(bus.out_sum), 4'(err_cnt)}, '0);
        ref_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vcount++;
        end
        check("no_stale_valid", 64'(vcount), 0);
        check("ready_after_reset", bus.in_ready, 1);
        do_op(32'h0000_1234, 32'h0000_0101, MODE_SPEC, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
